// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier. It has one WIDTH-bit adder with carry-out,
// performs one conditional add and one right shift per cycle, and uses a start/busy/done handshake.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             last, load;

  // sum[WIDTH] is the adder carry. It becomes the top bit of hi after the shift.
  always_comb begin
    sum  = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
    last = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        cnt   <= '0;
      end else if (state == RUN) begin
        hi  <= sum[WIDTH:1];
        lo  <= {sum[0], lo[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        // This is the final step, so the shifted {carry, hi, lo} is the full product.
        if (last) product <= {sum, lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier. It runs directed cases and randomized traffic.
// The results are checked every cycle against a cycle-count/a*b reference model.
module tb_shift_add_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  int n_chk = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  // Reference model: the number of busy cycles left, plus the pending exact product a*b.
  int             m_left = 0;
  bit             m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;
  int             done_cnt = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_prod = '0;
      armed  = 1'b1;
    end else begin
      bit accept;
      accept = start && (m_left == 0);
      m_done = (m_left == 1);
      if (m_left == 1) m_prod = m_pend;
      if (m_left > 0) m_left--;
      if (accept) begin
        m_left = W;
        m_pend = (2*W)'(a) * (2*W)'(b);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("product", {16'd0, product}, {16'd0, m_prod});
      if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic go(input logic [W-1:0] ai, input logic [W-1:0] bi);
    @(negedge clk);
    start = 1'b1; a = ai; b = bi;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int busy_n;
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'h0);
    rst_n = 1'b1;

    // 0x0F * 0x01, with busy high for exactly 8 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_n, 8);
    chk("p_0f_01", {16'd0, product}, 32'h000F);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    go(8'hFF, 8'hFF);
    wait_done("ffff");
    chk("p_ff_ff", {16'd0, product}, 32'hFE01);

    // Back-to-back operations, with the second start raised during the done cycle.
    go(8'hAA, 8'h55);
    wait_done("aa55");
    chk("p_aa_55", {16'd0, product}, 32'h3872);
    start = 1'b1; a = 8'h00; b = 8'h37;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("0037");
    chk("p_00_37", {16'd0, product}, 32'h0000);

    // A start raised while busy must be ignored.
    go(8'hFE, 8'h01);
    @(negedge clk);
    start = 1'b1; a = 8'h02; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    wait_done("fe01");
    chk("p_ignored", {16'd0, product}, 32'h00FE);
    @(negedge clk);
    go(8'h02, 8'h02);
    wait_done("0202");
    chk("p_02_02", {16'd0, product}, 32'h0004);

    // Reset during an operation aborts it.
    go(8'hFF, 8'h01);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'h0);
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    go(8'h01, 8'h01);
    wait_done("0101");
    chk("p_01_01", {16'd0, product}, 32'h0001);

    // Operand inputs change while busy; the product must then hold through idle.
    go(8'h10, 8'h10);
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    chk("p_10_10", {16'd0, product}, 32'h0100);
    @(negedge clk);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("hold_product", {16'd0, product}, 32'h0100);
    chk("hold_no_done", done_cnt, d0);

    // Randomized traffic: held starts, starts while busy, and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) != 0);
      a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 3) == 0) a = 8'hFF;
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
